// File: rtl/colour_lut_arbiter.sv
// Two-master arbiter for the pixel-side port of the 256x32 colour LUT.
// Master A (pixel colouring, read-only) has weighted priority over master B
// (palette engine, read/write). A consecutive-grant counter makes sure B is
// served at least once every MAX_CONSEC+1 contended cycles. Read data from the
// LUT is broadcast to both masters; the registered valid flags select the owner.
module colour_lut_arbiter #(
  parameter int unsigned MAX_CONSEC = 4  // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset_n,
  // master A: pixel colouring pipeline
  input  logic [7:0]  a_address,
  input  logic        a_read,
  output logic        a_waitrequest,
  output logic [31:0] a_readdata,
  output logic        a_readdatavalid,
  // master B: palette update/rotation engine
  input  logic [7:0]  b_address,
  input  logic        b_read,
  input  logic        b_write,
  input  logic [3:0]  b_byteenable,
  input  logic [31:0] b_writedata,
  output logic        b_waitrequest,
  output logic [31:0] b_readdata,
  output logic        b_readdatavalid,
  // LUT port
  output logic [7:0]  lut_address,
  output logic [3:0]  lut_byteenable,
  output logic        lut_chipselect,
  output logic        lut_write,
  output logic [31:0] lut_writedata,
  output logic        lut_clken,
  input  logic [31:0] lut_readdata
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_CONSEC);

  logic       req_a;
  logic       req_b;
  logic       grant_a;
  logic       grant_b;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       rdv_a_q;
  logic       rdv_a_d;
  logic       rdv_b_q;
  logic       rdv_b_d;

  // Request decode and weighted-priority arbitration; no grants while in reset.
  always_comb begin
    req_a   = a_read;
    req_b   = b_read | b_write;
    grant_a = 1'b0;
    grant_b = 1'b0;
    cnt_d   = 4'd0;
    if (reset_n) begin
      if (req_a && req_b) begin
        // >= rather than == so an out-of-range count can never starve B
        if (cnt_q >= MAX_CNT) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
          cnt_d   = cnt_q + 4'd1;
        end
      end else if (req_a) begin
        grant_a = 1'b1;
      end else if (req_b) begin
        grant_b = 1'b1;
      end
    end
    // A read+write from B is treated as a write: no read response is owed
    rdv_a_d = grant_a;
    rdv_b_d = grant_b & b_read & ~b_write;
  end

  // LUT port drive: address/enables follow the granted master, idle defaults otherwise.
  always_comb begin
    lut_address    = a_address;
    lut_byteenable = 4'hF;
    lut_chipselect = 1'b0;
    lut_write      = 1'b0;
    lut_writedata  = b_writedata;
    if (grant_a) begin
      lut_chipselect = 1'b1;
    end else if (grant_b) begin
      lut_address    = b_address;
      lut_byteenable = b_write ? b_byteenable : 4'hF;
      lut_write      = b_write;
      lut_chipselect = 1'b1;
    end
  end

  // Consecutive-grant counter and read-valid flags; reset drops in-flight valids.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= 4'd0;
      rdv_a_q <= 1'b0;
      rdv_b_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdv_a_q <= rdv_a_d;
      rdv_b_q <= rdv_b_d;
    end
  end

  // Both masters are held off while reset is asserted.
  assign a_waitrequest   = ~reset_n | (req_a & ~grant_a);
  assign b_waitrequest   = ~reset_n | (req_b & ~grant_b);

  assign a_readdata      = lut_readdata;
  assign b_readdata      = lut_readdata;
  assign a_readdatavalid = rdv_a_q;
  assign b_readdatavalid = rdv_b_q;

  assign lut_clken       = 1'b1;

endmodule

// File: tb/tb_colour_lut_arbiter.sv
// Bench for colour_lut_arbiter: behavioural LUT model, vector table with a
// read-data scoreboard, plus hand-written contention and reset sequences.
module tb_colour_lut_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  a_address;
  logic        a_read;
  logic        a_waitrequest;
  logic [31:0] a_readdata;
  logic        a_readdatavalid;
  logic [7:0]  b_address;
  logic        b_read;
  logic        b_write;
  logic [3:0]  b_byteenable;
  logic [31:0] b_writedata;
  logic        b_waitrequest;
  logic [31:0] b_readdata;
  logic        b_readdatavalid;
  logic [7:0]  lut_address;
  logic [3:0]  lut_byteenable;
  logic        lut_chipselect;
  logic        lut_write;
  logic [31:0] lut_writedata;
  logic        lut_clken;
  logic [31:0] lut_readdata;

  always #5 clk = ~clk;

  colour_lut_arbiter #(.MAX_CONSEC(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .a_address       (a_address),
    .a_read          (a_read),
    .a_waitrequest   (a_waitrequest),
    .a_readdata      (a_readdata),
    .a_readdatavalid (a_readdatavalid),
    .b_address       (b_address),
    .b_read          (b_read),
    .b_write         (b_write),
    .b_byteenable    (b_byteenable),
    .b_writedata     (b_writedata),
    .b_waitrequest   (b_waitrequest),
    .b_readdata      (b_readdata),
    .b_readdatavalid (b_readdatavalid),
    .lut_address     (lut_address),
    .lut_byteenable  (lut_byteenable),
    .lut_chipselect  (lut_chipselect),
    .lut_write       (lut_write),
    .lut_writedata   (lut_writedata),
    .lut_clken       (lut_clken),
    .lut_readdata    (lut_readdata)
  );

  // LUT port model: registered address, unregistered output, byte-enabled writes
  logic [31:0] mem [256];
  logic [7:0]  lut_aq = 8'd0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'd0;
  logic [31:0] pl_data = 32'd0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (lut_chipselect && lut_clken) begin
      lut_aq <= lut_address;
      if (lut_write)
        for (int i = 0; i < 4; i++)
          if (lut_byteenable[i]) mem[lut_address][8*i +: 8] <= lut_writedata[8*i +: 8];
    end
  end
  assign lut_readdata = mem[lut_aq];

  typedef struct {
    logic        a_rd;
    logic [7:0]  a_ad;
    logic        b_rd;
    logic        b_wr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [7:0]  b_ad;
    logic        ea_wait;
    logic        eb_wait;
  } vec_t;

  typedef struct {
    int          c;
    logic [31:0] d;
  } exp_t;

  logic [31:0] ref_mem [256];
  exp_t        qa[$];
  exp_t        qb[$];
  vec_t        tbl[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          b_rdv_seen = 0;

  function automatic vec_t mk(input logic a_rd, input logic [7:0] a_ad,
                              input logic b_rd, input logic b_wr, input logic [3:0] be,
                              input logic [31:0] wd, input logic [7:0] b_ad,
                              input logic ea, input logic eb);
    vec_t v;
    v.a_rd = a_rd; v.a_ad = a_ad; v.b_rd = b_rd; v.b_wr = b_wr; v.be = be;
    v.wd = wd; v.b_ad = b_ad; v.ea_wait = ea; v.eb_wait = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, required %b (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Called at the falling edge of each cycle: compare read responses against the scoreboard
  task automatic monitor();
    if (b_readdatavalid === 1'b1) b_rdv_seen++;
    if (qa.size() > 0 && qa[0].c == cyc) begin
      chk1("a_readdatavalid", a_readdatavalid, 1'b1);
      chk("a_readdata", a_readdata, qa[0].d);
      void'(qa.pop_front());
    end else begin
      chk1("a_readdatavalid_idle", a_readdatavalid, 1'b0);
    end
    if (qb.size() > 0 && qb[0].c == cyc) begin
      chk1("b_readdatavalid", b_readdatavalid, 1'b1);
      chk("b_readdata", b_readdata, qb[0].d);
      void'(qb.pop_front());
    end else begin
      chk1("b_readdatavalid_idle", b_readdatavalid, 1'b0);
    end
  endtask

  task automatic apply(input vec_t v);
    logic ga;
    logic gb;
    exp_t e;
    a_read = v.a_rd; a_address = v.a_ad;
    b_read = v.b_rd; b_write = v.b_wr; b_byteenable = v.be;
    b_writedata = v.wd; b_address = v.b_ad;
    ga = v.a_rd & ~v.ea_wait;
    gb = (v.b_rd | v.b_wr) & ~v.eb_wait;
    @(negedge clk);
    chk1("a_waitrequest", a_waitrequest, v.ea_wait);
    chk1("b_waitrequest", b_waitrequest, v.eb_wait);
    chk1("lut_chipselect", lut_chipselect, ga | gb);
    chk1("lut_write", lut_write, gb & v.b_wr);
    chk("lut_address", {24'd0, lut_address}, {24'd0, (gb ? v.b_ad : v.a_ad)});
    chk("lut_byteenable", {28'd0, lut_byteenable}, {28'd0, ((gb & v.b_wr) ? v.be : 4'hF)});
    if (!ga) chk("lut_writedata", lut_writedata, v.wd);
    monitor();
    if (ga) begin
      e.c = cyc + 1; e.d = ref_mem[v.a_ad]; qa.push_back(e);
    end
    if (gb & v.b_rd & ~v.b_wr) begin
      e.c = cyc + 1; e.d = ref_mem[v.b_ad]; qb.push_back(e);
    end
    if (gb & v.b_wr)
      for (int i = 0; i < 4; i++)
        if (v.be[i]) ref_mem[v.b_ad][8*i +: 8] = v.wd[8*i +: 8];
    next_cycle();
  endtask

  task automatic idle();
    apply(mk(1'b0, 8'h00, 1'b0, 1'b0, 4'hF, 32'd0, 8'h00, 1'b0, 1'b0));
  endtask

  initial begin
    logic gb_exp;
    int   ai;
    int   bk;

    reset_n = 1'b0;
    a_read = 1'b1; a_address = 8'h00;
    b_read = 1'b0; b_write = 1'b1; b_byteenable = 4'hF;
    b_writedata = 32'd0; b_address = 8'h00;

    // Preload the LUT while reset holds both masters off
    for (int k = 0; k < 256; k++) begin
      pl_en = 1'b1; pl_addr = 8'(k); pl_data = 32'h00010101 * 32'(k);
      ref_mem[k] = 32'h00010101 * 32'(k);
      @(posedge clk); #1;
    end
    pl_addr = 8'h10; pl_data = 32'hAABBCCDD; ref_mem[8'h10] = 32'hAABBCCDD;
    @(posedge clk); #1;
    pl_en = 1'b0;

    // Reset state with A read and B write both asserted
    @(negedge clk);
    chk1("rst_a_waitrequest", a_waitrequest, 1'b1);
    chk1("rst_b_waitrequest", b_waitrequest, 1'b1);
    chk1("rst_lut_chipselect", lut_chipselect, 1'b0);
    chk1("rst_lut_write", lut_write, 1'b0);
    chk1("rst_lut_clken", lut_clken, 1'b1);
    chk1("rst_a_readdatavalid", a_readdatavalid, 1'b0);
    chk1("rst_b_readdatavalid", b_readdatavalid, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // First cycle after release: B only, accepted at once
    apply(mk(1'b0, 8'h00, 1'b0, 1'b1, 4'hF, 32'hCAFEF00D, 8'h30, 1'b0, 1'b0));

    // Vector table
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 4'hF, 32'd0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 4'hF, 32'd0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h02, 1'b0, 1'b0, 4'hF, 32'd0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h03, 1'b0, 1'b0, 4'hF, 32'd0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h55, 1'b0, 1'b0, 4'hF, 32'h11223344, 8'h66, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 4'b0011, 32'h00FF00FF, 8'h10, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 4'hF, 32'd0, 8'h10, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 4'hF, 32'd0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 4'hF, 32'h12345678, 8'h20, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 4'hF, 32'd0, 8'h20, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 4'hF, 32'd0, 8'h30, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h07, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 8'h08, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h07, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 8'h08, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 4'hF, 32'd0, 8'h08, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 4'hF, 32'd0, 8'h00, 1'b0, 1'b0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Contention: both read for 15 cycles, expected AAAAB AAAAB AAAAB
    b_rdv_seen = 0;
    ai = 0; bk = 0;
    for (int i = 0; i < 15; i++) begin
      gb_exp = ((i % 5) == 4);
      apply(mk(1'b1, 8'(ai), 1'b1, 1'b0, 4'hF, 32'd0, 8'(8'h40 + bk), gb_exp, ~gb_exp));
      if (gb_exp) bk++; else ai++;
    end
    idle();
    chk("b_readdatavalid_count", 32'(b_rdv_seen), 32'd3);

    // Reset mid-read: build up the counter, then reset 1 ns after an accepted A read
    apply(mk(1'b1, 8'h01, 1'b1, 1'b0, 4'hF, 32'd0, 8'h02, 1'b0, 1'b1));
    apply(mk(1'b1, 8'h02, 1'b1, 1'b0, 4'hF, 32'd0, 8'h02, 1'b0, 1'b1));
    reset_n = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    chk1("midrst_a_readdatavalid_now", a_readdatavalid, 1'b0);
    chk1("midrst_a_waitrequest", a_waitrequest, 1'b1);
    chk1("midrst_b_waitrequest", b_waitrequest, 1'b1);
    @(negedge clk);
    chk1("midrst_a_readdatavalid_n1", a_readdatavalid, 1'b0);
    chk1("midrst_lut_chipselect", lut_chipselect, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("midrst_a_readdatavalid_n2", a_readdatavalid, 1'b0);
    next_cycle();
    reset_n = 1'b1;
    // Counter must restart from zero: four A grants before B
    ai = 3;
    for (int i = 0; i < 5; i++) begin
      gb_exp = (i == 4);
      apply(mk(1'b1, 8'(ai), 1'b1, 1'b0, 4'hF, 32'd0, 8'h02, gb_exp, ~gb_exp));
      if (!gb_exp) ai++;
    end
    idle();
    idle();

    chk("scoreboard_a_drained", 32'(qa.size()), 32'd0);
    chk("scoreboard_b_drained", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
